// File: rtl/local_flit_injector.sv
// Packet-to-flit sequencer for one router local input port: turns a packet
// request into head, body and tail flits, writing only while the buffer has room.
module local_flit_injector #(
  parameter int LINK_WIDTHS  = 8,
  parameter int MESH_ROWS    = 4,
  parameter int MESH_COLUMNS = 4,
  parameter int LEN_W        = 3,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_dest_row,
  input  logic [2:0]             req_dest_col,
  input  logic [LEN_W-1:0]       req_len,
  input  logic                   local_full,
  output logic [LINK_WIDTHS-1:0] out_flit,
  output logic                   out_wr_en,
  output logic                   req_drop,
  output logic [CNT_W-1:0]       pkt_sent,
  output logic [CNT_W-1:0]       flit_sent
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

  localparam logic [1:0] TYPE_HEAD = 2'b00;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam logic [3:0] ROWS_L    = 4'(MESH_ROWS);
  localparam logic [3:0] COLS_L    = 4'(MESH_COLUMNS);

  state_t                   state, state_next;
  logic [LEN_W-1:0]         body_cnt;
  logic [5:0]               seq, seq_next, seq_inc;
  logic [LINK_WIDTHS-1:0]   flit_next;
  logic                     accept, dest_ok;

  // Handshake: a request transfers on a cycle where req_valid && req_ready;
  // the requester must hold req_valid and its fields stable until then.
  always_comb begin
    state_next = state;
    flit_next  = out_flit;
    seq_next   = seq;
    seq_inc    = seq + 6'd1;
    req_ready  = (state == IDLE) && rst;
    accept     = req_valid && req_ready;
    dest_ok    = ({1'b0, req_dest_row} < ROWS_L) && ({1'b0, req_dest_col} < COLS_L);
    out_wr_en  = (state != IDLE) && !local_full;
    case (state)
      IDLE: begin
        if (accept && dest_ok) begin
          state_next = HEAD;
          flit_next  = {req_dest_row, req_dest_col, TYPE_HEAD};
        end
      end
      HEAD: begin
        // The head write loads the first payload flit, which reuses the current seq.
        if (out_wr_en) begin
          if (body_cnt == '0) begin
            state_next = TAIL;
            flit_next  = {seq, TYPE_TAIL};
          end else begin
            state_next = BODY;
            flit_next  = {seq, TYPE_BODY};
          end
        end
      end
      BODY: begin
        if (out_wr_en) begin
          seq_next = seq_inc;
          if (body_cnt == LEN_W'(1)) begin
            state_next = TAIL;
            flit_next  = {seq_inc, TYPE_TAIL};
          end else begin
            flit_next  = {seq_inc, TYPE_BODY};
          end
        end
      end
      TAIL: begin
        if (out_wr_en) begin
          seq_next   = seq_inc;
          state_next = IDLE;
          flit_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      out_flit  <= '0;
      seq       <= '0;
      body_cnt  <= '0;
      req_drop  <= 1'b0;
      pkt_sent  <= '0;
      flit_sent <= '0;
    end else begin
      state    <= state_next;
      out_flit <= flit_next;
      seq      <= seq_next;
      req_drop <= accept && !dest_ok;
      if (accept && dest_ok)
        body_cnt <= req_len;
      else if (state == BODY && out_wr_en)
        body_cnt <= body_cnt - LEN_W'(1);
      if (out_wr_en)
        flit_sent <= flit_sent + CNT_W'(1);
      if (state == TAIL && out_wr_en)
        pkt_sent <= pkt_sent + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_local_flit_injector.sv
// Directed bench for local_flit_injector: per-cycle vector table plus a
// scoreboarded long packet under an alternating full pattern.
module tb_local_flit_injector;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_dest_row;
  logic [2:0]  req_dest_col;
  logic [2:0]  req_len;
  logic        local_full;
  logic [7:0]  out_flit;
  logic        out_wr_en;
  logic        req_drop;
  logic [15:0] pkt_sent;
  logic [15:0] flit_sent;

  int total = 0;
  int bad   = 0;

  local_flit_injector dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_row(req_dest_row), .req_dest_col(req_dest_col), .req_len(req_len),
    .local_full(local_full), .out_flit(out_flit), .out_wr_en(out_wr_en),
    .req_drop(req_drop), .pkt_sent(pkt_sent), .flit_sent(flit_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [2:0]  len;
    logic        full;
    logic        ready;
    logic        wr;
    logic [7:0]  flit;
    logic        drop;
    logic [15:0] pkt;
    logic [15:0] fs;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];

  function automatic vec_t mk(logic r, logic v, logic [2:0] row, logic [2:0] col,
                              logic [2:0] len, logic full, logic rdy, logic wr,
                              logic [7:0] flit, logic drop, logic [15:0] pkt,
                              logic [15:0] fs);
    vec_t x;
    x.rst = r; x.valid = v; x.row = row; x.col = col; x.len = len; x.full = full;
    x.ready = rdy; x.wr = wr; x.flit = flit; x.drop = drop; x.pkt = pkt; x.fs = fs;
    return x;
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_dest_row = '0; req_dest_col = '0;
    req_len = '0; local_full = 1'b0;

    // Each entry: inputs for one cycle, and outputs expected before that cycle's edge.
    //             rst v  row col len full rdy wr flit  drop pkt fs
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0)); // 0 reset held
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0)); // 1 released
    vecs.push_back(mk(1, 1, 3, 3, 2, 0,  1, 0, 8'h00, 0, 0, 0)); // 2 req (3,3) len2
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h6C, 0, 0, 0)); // 3 head
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h01, 0, 0, 1)); // 4 body seq0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h05, 0, 0, 2)); // 5 body seq1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h0A, 0, 0, 3)); // 6 tail seq2
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0, 1, 4)); // 7 idle gap
    vecs.push_back(mk(1, 1, 4, 0, 1, 0,  1, 0, 8'h00, 0, 1, 4)); // 8 bad row
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 1, 1, 4)); // 9 drop pulse
    vecs.push_back(mk(1, 1, 0, 5, 0, 0,  1, 0, 8'h00, 0, 1, 4)); // 10 bad col
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 1, 1, 4)); // 11 drop pulse
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0, 1, 4)); // 12 pulse ends
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0, 1, 4)); // 13 reset clears seq
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0)); // 14
    vecs.push_back(mk(1, 1, 1, 2, 0, 0,  1, 0, 8'h00, 0, 0, 0)); // 15 req (1,2) len0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h28, 0, 0, 0)); // 16 head
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h02, 0, 0, 1)); // 17 tail seq0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0, 1, 2)); // 18
    vecs.push_back(mk(1, 1, 2, 1, 3, 0,  1, 0, 8'h00, 0, 1, 2)); // 19 req (2,1) len3
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h44, 0, 1, 2)); // 20 head
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1, 8'h05, 0, 1, 3)); // 21 body seq1, busy req ignored
    vecs.push_back(mk(1, 1, 0, 0, 0, 1,  0, 0, 8'h09, 0, 1, 4)); // 22 full: hold 2nd body
    vecs.push_back(mk(1, 1, 0, 0, 0, 1,  0, 0, 8'h09, 0, 1, 4)); // 23
    vecs.push_back(mk(1, 1, 0, 0, 0, 1,  0, 0, 8'h09, 0, 1, 4)); // 24
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h09, 0, 1, 4)); // 25 resume
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h0D, 0, 1, 5)); // 26 body seq3
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h12, 0, 1, 6)); // 27 tail seq4
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0, 2, 7)); // 28
    vecs.push_back(mk(1, 1, 3, 0, 4, 0,  1, 0, 8'h00, 0, 2, 7)); // 29 req (3,0) len4
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h60, 0, 2, 7)); // 30 head
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 8'h15, 0, 2, 8)); // 31 reset mid-body
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0, 0, 0)); // 32 back in IDLE
    vecs.push_back(mk(1, 1, 0, 1, 1, 0,  1, 0, 8'h00, 0, 0, 0)); // 33 req (0,1) len1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h04, 0, 0, 0)); // 34 head
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h01, 0, 0, 1)); // 35 body seq0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 8'h06, 0, 0, 2)); // 36 tail seq1
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 8'h00, 0, 1, 3)); // 37 full while idle

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req_valid = vecs[i].valid; req_dest_row = vecs[i].row;
      req_dest_col = vecs[i].col; req_len = vecs[i].len; local_full = vecs[i].full;
      #1;
      check("req_ready", i, 16'(req_ready), 16'(vecs[i].ready));
      check("out_wr_en", i, 16'(out_wr_en), 16'(vecs[i].wr));
      check("out_flit",  i, 16'(out_flit),  16'(vecs[i].flit));
      check("req_drop",  i, 16'(req_drop),  16'(vecs[i].drop));
      check("pkt_sent",  i, pkt_sent,       vecs[i].pkt);
      check("flit_sent", i, flit_sent,      vecs[i].fs);
    end

    // Long packet (2,2) len7 with local_full toggling; seq continues from 2.
    exp_q.push_back(8'h48);
    for (int s = 2; s <= 8; s++) exp_q.push_back({6'(s), 2'b01});
    exp_q.push_back({6'd9, 2'b10});

    @(negedge clk);
    local_full = 1'b0; req_valid = 1'b1; req_dest_row = 3'd2; req_dest_col = 3'd2;
    req_len = 3'd7;
    #1;
    check("long_req_ready", 0, 16'(req_ready), 16'd1);
    begin
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
        @(negedge clk);
        req_valid = 1'b0;
        local_full = cyc[0];
        #1;
        if (out_wr_en) check("long_flit", cyc, 16'(out_flit), 16'(exp_q.pop_front()));
        cyc++;
      end
      if (exp_q.size() > 0) begin
        total++; bad++;
        $display("FAIL long_timeout left=%0d want=0", exp_q.size());
      end
    end
    @(negedge clk);
    local_full = 1'b0;
    #1;
    check("long_pkt_sent",  0, pkt_sent,          16'd2);
    check("long_flit_sent", 0, flit_sent,         16'd12);
    check("long_ready",     0, 16'(req_ready),    16'd1);
    check("long_wr_idle",   0, 16'(out_wr_en),    16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
